fifo: RTL and testbench
=======================

Name: fifo

Overview:
Single-clock synchronous FIFO buffering byte-wide data between a producer and a consumer in the same clock domain. The producer pushes with `write_en`. The consumer pops with `read_en` and receives the data one cycle later, qualified by `read_valid`. Status flags `full` and `empty` are provided for flow control.

Parameters:
- DATA_WIDTH, 8, width of data_in/data_out in bits.
- DEPTH, 16, number of storage entries; must be a power of 2, at least 2.
- ADDR_WIDTH, $clog2(DEPTH), pointer index width; derived, not overridden.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  reset.
- data_in  input  DATA_WIDTH  write data, sampled when a write is accepted.
- write_en  input  1  write request.
- data_out  output  DATA_WIDTH  read data, registered.
- read_en  input  1  read request.
- read_valid  output  1  data_out holds newly popped data this cycle.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.

Interface note: one clock, clk; reset is synchronous and active-high, on port rst_n. rst_n keeps the codebase's port name but is asserted at logic 1, and is sampled only on the rising edge of clk.

Behaviour:
- Storage: DEPTH x DATA_WIDTH register array; memory contents are not reset.
- Pointers: wr_ptr and rd_ptr are ADDR_WIDTH+1 bits wide. The extra MSB distinguishes full from empty.
  - empty = (wr_ptr == rd_ptr).
  - full = MSBs differ and lower bits are equal.
  - Both flags are combinational from the registered pointers.
- Reset (rst_n=1 at a rising edge):
  - wr_ptr=0, rd_ptr=0, data_out=0, read_valid=0, so empty=1 and full=0.
  - Reset takes priority over every other event, including reset asserted mid-operation; pending data is discarded.
- Write accept = write_en & ~full.
  - On accept: mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in and wr_ptr increments.
  - A write while full is dropped silently; pointers and contents are unchanged.
- Read accept = read_en & ~empty.
  - On accept: data_out <= mem[rd_ptr[ADDR_WIDTH-1:0]], rd_ptr increments, and read_valid <= 1 at the same edge.
  - Data is therefore visible one cycle after read_en is sampled.
  - Otherwise read_valid <= 0 and data_out holds its last value.
  - A read while empty is ignored, with read_valid=0.
- Simultaneous write and read:
  - Each is accepted independently per the rules above.
  - When not empty and not full, both occur and occupancy is unchanged.
  - When empty, only the write is accepted; there is no fall-through, and the new word is readable from the next cycle.
  - When full, only the read is accepted; the write is dropped even though a slot frees that cycle.
- Wrap-around: pointers wrap naturally modulo 2*DEPTH. The index wraps after DEPTH-1 back to 0, and ordering is preserved across the wrap.
- Flag timing: flags update in the cycle after the accepting edge.
  - After the DEPTH-th write, full=1.
  - After the last read, empty=1.
- Back-to-back reads with read_en held high produce one word per cycle with read_valid continuously high until empty.

Test Plan:
- Reset check: hold rst_n=1 for 5 cycles, then release to 0 -> data_out=0, read_valid=0, empty=1, full=0.
- Basic order: write 0,1,2,3,4 on consecutive cycles, idle, then assert read_en for 5 cycles -> data_out=0,1,2,3,4 on the 5 cycles each following a read, read_valid=1 on exactly those cycles, then empty=1.
- Full/overflow: write 0x00..0x0F (16 words), then attempt to write 0xAA -> full=1 after the 16th write, 0xAA dropped; draining yields 0x00..0x0F only, then empty=1.
- Underflow: read_en=1 for 3 cycles on an empty FIFO -> read_valid stays 0, data_out unchanged, pointers unchanged.
- Simultaneous and wrap: preload 10 words, then run 20 cycles with write_en=read_en=1 using incrementing data -> occupancy stays 10, output continues in order across the index wrap, and full/empty stay 0.
- Mid-operation reset: write 3 words, pulse rst_n=1 for one cycle, then read -> empty=1 and read_valid=0; the old words are not returned.

Source files
------------

// File: rtl/fifo.sv
// Single-clock byte FIFO with registered read data and full/empty flags.
// Pointers carry one extra wrap bit so equal indices can be told apart as full or empty.
module fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  write_en,
   output logic [DATA_WIDTH-1:0] data_out,
   input  logic                  read_en,
   output logic                  read_valid,
   output logic                  full,
   output logic                  empty
);

   localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH:0]   wr_ptr;
   logic [ADDR_WIDTH:0]   rd_ptr;
   logic                  write_accept;
   logic                  read_accept;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                  (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

   assign write_accept = write_en & ~full;
   assign read_accept  = read_en & ~empty;

   // Storage is deliberately left unreset; only the pointers define valid contents.
   always_ff @(posedge clk) begin
      if (!rst_n && write_accept) begin
         mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         data_out   <= '0;
         read_valid <= 1'b0;
      end else begin
         if (write_accept) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (read_accept) begin
            data_out   <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            rd_ptr     <= rd_ptr + PTR_ONE;
            read_valid <= 1'b1;
         end else begin
            read_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fifo.sv
// Directed self-checking bench for fifo; expected values are hand-derived constants and counters.
module tb_fifo;

   logic       clk;
   logic       rst_n;
   logic [7:0] data_in;
   logic       write_en;
   logic [7:0] data_out;
   logic       read_en;
   logic       read_valid;
   logic       full;
   logic       empty;

   int check_count;
   int pass_count;

   fifo #(.DATA_WIDTH(8), .DEPTH(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_in    (data_in),
      .write_en   (write_en),
      .data_out   (data_out),
      .read_en    (read_en),
      .read_valid (read_valid),
      .full       (full),
      .empty      (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      check_count++;
      if (actual === expected) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   // Drives one cycle of inputs, then lets outputs settle 1ns past the edge.
   task automatic applyStimulus(input logic we, input logic [7:0] din, input logic re);
      write_en = we;
      data_in  = din;
      read_en  = re;
      @(posedge clk);
      #1;
   endtask

   initial begin
      check_count = 0;
      pass_count  = 0;
      rst_n    = 1'b1;
      write_en = 1'b0;
      read_en  = 1'b0;
      data_in  = 8'h00;

      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h00, 1'b0);
      rst_n = 1'b0;
      checkOutput("reset_data_out", 32'(data_out), 32'h0);
      checkOutput("reset_read_valid", 32'(read_valid), 32'h0);
      checkOutput("reset_empty", 32'(empty), 32'h1);
      checkOutput("reset_full", 32'(full), 32'h0);

      // Basic ordering
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 8'(i), 1'b0);
         checkOutput("basic_wr_read_valid", 32'(read_valid), 32'h0);
      end
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("basic_not_empty", 32'(empty), 32'h0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b1);
         checkOutput("basic_read_valid", 32'(read_valid), 32'h1);
         checkOutput("basic_data", 32'(data_out), 32'(i));
      end
      checkOutput("basic_empty_after", 32'(empty), 32'h1);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("basic_idle_valid", 32'(read_valid), 32'h0);
      checkOutput("basic_idle_hold", 32'(data_out), 32'h4);

      // Fill, overflow, drain
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 8'(i), 1'b0);
         checkOutput("fill_full", 32'(full), (i == 15) ? 32'h1 : 32'h0);
      end
      applyStimulus(1'b1, 8'hAA, 1'b0);
      checkOutput("overflow_full", 32'(full), 32'h1);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b1);
         checkOutput("drain_valid", 32'(read_valid), 32'h1);
         checkOutput("drain_data", 32'(data_out), 32'(i));
         checkOutput("drain_full", 32'(full), 32'h0);
      end
      checkOutput("drain_empty", 32'(empty), 32'h1);

      // Underflow leaves state untouched
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b1);
         checkOutput("underflow_valid", 32'(read_valid), 32'h0);
         checkOutput("underflow_hold", 32'(data_out), 32'h0F);
         checkOutput("underflow_empty", 32'(empty), 32'h1);
      end
      applyStimulus(1'b1, 8'h55, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("post_underflow_data", 32'(data_out), 32'h55);
      checkOutput("post_underflow_empty", 32'(empty), 32'h1);

      // Simultaneous on empty: no fall-through
      applyStimulus(1'b1, 8'h77, 1'b1);
      checkOutput("sim_empty_valid", 32'(read_valid), 32'h0);
      checkOutput("sim_empty_not_empty", 32'(empty), 32'h0);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("sim_empty_data", 32'(data_out), 32'h77);
      checkOutput("sim_empty_valid2", 32'(read_valid), 32'h1);

      // Preload 10 then stream 20 cycles across the index wrap
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'(8'h10 + i), 1'b0);
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, 8'(8'h1A + i), 1'b1);
         checkOutput("stream_valid", 32'(read_valid), 32'h1);
         checkOutput("stream_data", 32'(data_out), 32'(8'h10 + i));
         checkOutput("stream_full", 32'(full), 32'h0);
         checkOutput("stream_empty", 32'(empty), 32'h0);
      end
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b1);
         checkOutput("stream_tail", 32'(data_out), 32'(8'h24 + i));
      end
      checkOutput("stream_end_empty", 32'(empty), 32'h1);

      // Simultaneous on full: read only, write dropped
      for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(8'h80 + i), 1'b0);
      checkOutput("sim_full_full", 32'(full), 32'h1);
      applyStimulus(1'b1, 8'hBB, 1'b1);
      checkOutput("sim_full_data", 32'(data_out), 32'h80);
      checkOutput("sim_full_not_full", 32'(full), 32'h0);
      for (int i = 1; i < 16; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b1);
         checkOutput("sim_full_drain", 32'(data_out), 32'(8'h80 + i));
      end
      checkOutput("sim_full_empty", 32'(empty), 32'h1);

      // Mid-operation reset, with a write pending in the reset cycle
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0);
      rst_n = 1'b1;
      applyStimulus(1'b1, 8'hEE, 1'b1);
      rst_n = 1'b0;
      checkOutput("midreset_empty", 32'(empty), 32'h1);
      checkOutput("midreset_valid", 32'(read_valid), 32'h0);
      checkOutput("midreset_data", 32'(data_out), 32'h0);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("midreset_read_valid", 32'(read_valid), 32'h0);
      checkOutput("midreset_read_empty", 32'(empty), 32'h1);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
